// File: rtl/cla_seq_adder.sv
// Multi-cycle wide adder: streams operands one nibble per clock through a 4-bit
// carry-lookahead slice, LSB nibble first, and registers the assembled sum.

module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p    = a ^ b;
  assign g    = a & b;
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
  assign s    = p ^ c[3:0];
  assign co   = c[4];
endmodule

module cla_seq_adder #(
  parameter int unsigned NIBBLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 ci,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] s,
  output logic                 co,
  output logic                 ovf
);
  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned CW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [W-1:0]    acc;
  logic [W-1:0]    acc_c;
  logic [CW-1:0]   cnt;
  logic            carry;
  logic            a_msb;
  logic            b_msb;
  logic [3:0]      slice_s;
  logic            slice_co;
  logic            last_c;

  cla4 u_slice (
    .a  (op_a[3:0]),
    .b  (op_b[3:0]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  assign last_c = (cnt == CW'(NIBBLES - 1));

  // Accumulator with the current slice sum merged into nibble cnt
  always_comb begin
    acc_c = acc;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (cnt == CW'(i)) acc_c[4*i +: 4] = slice_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_c) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            carry <= ci;
            a_msb <= a[W-1];
            b_msb <= b[W-1];
            cnt   <= '0;
          end
        end
        RUN: begin
          op_a  <= {4'b0, op_a[W-1:4]};
          op_b  <= {4'b0, op_b[W-1:4]};
          acc   <= acc_c;
          carry <= slice_co;
          cnt   <= cnt + CW'(1);
          // Outputs only move here, so partial sums are never visible
          if (last_c) begin
            s   <= acc_c;
            co  <= slice_co;
            ovf <= (a_msb == b_msb) && (slice_s[3] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder: vector table plus busy-protection and abort sequences.

module tb_cla_seq_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        ci;
  logic        busy;
  logic        done;
  logic [31:0] s;
  logic        co;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  logic [31:0] prev_s   = '0;
  logic        prev_co  = 1'b0;
  logic        prev_ovf = 1'b0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] es;
    logic        eco;
    logic        eovf;
  } vec_t;

  vec_t vecs[8];

  cla_seq_adder #(.NIBBLES(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // One operation; inj_k >= 0 pulses a stray start in RUN, abort_k >= 0 resets in RUN
  task automatic run_op(input logic [31:0] a_i, input logic [31:0] b_i, input logic ci_i,
                        input logic [31:0] es, input logic eco, input logic eovf,
                        input int inj_k, input int abort_k, input string nm);
    logic run_ok;
    logic quiet;
    run_ok = 1'b1;
    @(negedge clk);
    a = a_i; b = b_i; ci = ci_i; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; ci = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (busy !== 1'b1 || done !== 1'b0 || s !== prev_s || co !== prev_co || ovf !== prev_ovf)
        run_ok = 1'b0;
      if (k == inj_k) begin
        start = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; ci = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (k == abort_k) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({nm, "_run"}, 32'(run_ok), 32'd1);
        chk({nm, "_abort_busy"}, 32'(busy), 32'd0);
        chk({nm, "_abort_s"}, s, 32'h0);
        chk({nm, "_abort_co_ovf"}, {30'b0, co, ovf}, 32'd0);
        quiet = 1'b1;
        for (int j = 0; j < 12; j++) begin
          @(negedge clk);
          if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        chk({nm, "_abort_no_done"}, 32'(quiet), 32'd1);
        prev_s = '0; prev_co = 1'b0; prev_ovf = 1'b0;
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({nm, "_run"}, 32'(run_ok), 32'd1);
    chk({nm, "_done"}, {30'b0, done, busy}, 32'd2);
    chk({nm, "_s"}, s, es);
    chk({nm, "_co"}, 32'(co), 32'(eco));
    chk({nm, "_ovf"}, 32'(ovf), 32'(eovf));
    prev_s = es; prev_co = eco; prev_ovf = eovf;
    quiet = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (done !== 1'b0 || s !== prev_s || co !== prev_co || ovf !== prev_ovf) quiet = 1'b0;
    end
    chk({nm, "_after"}, 32'(quiet), 32'd1);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0005, 32'h0000_0004, 1'b0, 32'h0000_0009, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
    vecs[6] = '{32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 32'h1000_0000, 1'b0, 1'b0};
    vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

    // Reset held with start high must not launch an operation
    rst = 1'b1; start = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; ci = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_s", s, 32'h0);
    chk("rst_co_ovf", {30'b0, co, ovf}, 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_idle", {30'b0, busy, done}, 32'd0);

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].es, vecs[i].eco, vecs[i].eovf,
             -1, -1, $sformatf("vec%0d", i));

    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 3, -1, "busy_prot");
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h0, 1'b0, 1'b0, -1, 4, "abort");
    run_op(32'h0000_0010, 32'h0000_00F0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, -1, -1, "post_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
